// File: rtl/alu_nibble_seq.sv
// Nibble-serial ALU sequencer: runs WIDTH-bit ADD/SUB/XOR/AND/OR/RSHFT on an
// external combinational 4-bit ALU slice, one nibble per clock.

package alu_nibble_seq_pkg;

   typedef enum logic [2:0] {
      ALU_CMD_ADD   = 3'd0,
      ALU_CMD_XOR   = 3'd1,
      ALU_CMD_AND   = 3'd2,
      ALU_CMD_OR    = 3'd3,
      ALU_CMD_RSHFT = 3'd4
   } alu_cmd_e;

   typedef struct packed {
      logic [3:0] d1;
      logic [3:0] d2;
   } Alu4bitArgs;

   // RSHFT shifts carry_in into the nibble MSB even though carry_disable is set
   typedef struct packed {
      alu_cmd_e cmd;
      logic     carry_in;
      logic     carry_disable;
      logic     b_inv;
   } AluCtrl;

   typedef enum logic [2:0] {
      OP_ADD   = 3'd0,
      OP_SUB   = 3'd1,
      OP_XOR   = 3'd2,
      OP_AND   = 3'd3,
      OP_OR    = 3'd4,
      OP_RSHFT = 3'd5
   } req_op_e;

endpackage

module alu_nibble_seq
   import alu_nibble_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [2:0]       req_op,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_res,
   output logic             rsp_carry,
   output logic             rsp_zero,
   output logic             rsp_err,
   output logic             busy,
   output Alu4bitArgs       alu_args,
   output AluCtrl           alu_ctrl,
   input  logic [3:0]       alu_res,
   input  logic             alu_carry_out
);

   localparam int unsigned N  = WIDTH / 4;
   localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e           state_q;
   req_op_e          op_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] res_q;
   logic [KW-1:0]    k_q;
   logic             chain_q;
   logic             carry_q;
   logic             zero_q;
   logic             err_q;

   logic [KW-1:0]    idx;
   logic [3:0]       nib_a;
   logic [3:0]       nib_b;
   logic [WIDTH-1:0] res_d;
   logic             chain_d;
   logic             last;
   logic             op_legal;

   assign op_legal = (req_op <= 3'(OP_RSHFT));

   always_comb begin
      idx      = (op_q == OP_RSHFT) ? (KW'(N - 1) - k_q) : k_q;
      nib_a    = a_q[4*idx +: 4];
      nib_b    = b_q[4*idx +: 4];
      last     = (k_q == KW'(N - 1));
      alu_args = '0;
      alu_ctrl = '0;
      if (state_q == S_RUN) begin
         alu_args.d1 = nib_a;
         alu_args.d2 = nib_b;
         unique case (op_q)
            OP_ADD, OP_SUB: begin
               alu_ctrl.cmd      = ALU_CMD_ADD;
               alu_ctrl.carry_in = chain_q;
            end
            OP_XOR: begin
               alu_ctrl.cmd           = ALU_CMD_XOR;
               alu_ctrl.carry_disable = 1'b1;
            end
            OP_AND: begin
               alu_ctrl.cmd           = ALU_CMD_AND;
               alu_ctrl.carry_disable = 1'b1;
            end
            OP_OR: begin
               alu_ctrl.cmd           = ALU_CMD_OR;
               alu_ctrl.carry_disable = 1'b1;
            end
            OP_RSHFT: begin
               alu_ctrl.cmd           = ALU_CMD_RSHFT;
               alu_ctrl.carry_in      = chain_q;
               alu_ctrl.carry_disable = 1'b1;
            end
            default: alu_ctrl = '0;
         endcase
      end
      res_d              = res_q;
      res_d[4*idx +: 4]  = alu_res;
      chain_d            = chain_q;
      unique case (op_q)
         OP_ADD, OP_SUB: chain_d = alu_carry_out;
         OP_RSHFT:       chain_d = nib_b[0];
         default:        chain_d = chain_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         op_q    <= OP_ADD;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         k_q     <= '0;
         chain_q <= 1'b0;
         carry_q <= 1'b0;
         zero_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  k_q     <= '0;
                  res_q   <= '0;
                  carry_q <= 1'b0;
                  a_q     <= req_a;
                  if (op_legal) begin
                     op_q    <= req_op_e'(req_op);
                     // SUB runs as a + ~b + 1: invert b here, seed the chain with 1
                     b_q     <= (req_op_e'(req_op) == OP_SUB) ? ~req_b : req_b;
                     chain_q <= (req_op_e'(req_op) == OP_SUB);
                     zero_q  <= 1'b0;
                     err_q   <= 1'b0;
                     state_q <= S_RUN;
                  end else begin
                     op_q    <= OP_ADD;
                     b_q     <= req_b;
                     chain_q <= 1'b0;
                     zero_q  <= 1'b1;
                     err_q   <= 1'b1;
                     state_q <= S_DONE;
                  end
               end
            end
            S_RUN: begin
               res_q   <= res_d;
               chain_q <= chain_d;
               if (last) begin
                  carry_q <= chain_d;
                  zero_q  <= (res_d == '0);
                  state_q <= S_DONE;
               end else begin
                  k_q <= k_q + KW'(1);
               end
            end
            S_DONE: begin
               if (rsp_ready) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign req_ready = (state_q == S_IDLE);
   assign rsp_valid = (state_q == S_DONE);
   assign busy      = (state_q != S_IDLE);
   assign rsp_res   = res_q;
   assign rsp_carry = carry_q;
   assign rsp_zero  = zero_q;
   assign rsp_err   = err_q;

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Scoreboard bench for alu_nibble_seq with a behavioural 4-bit ALU slice;
// directed vectors push expectations, a negedge monitor pops and compares.

module tb_alu_nibble_seq;
   import alu_nibble_seq_pkg::*;

   localparam int unsigned W = 16;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         req_valid;
   logic         req_ready;
   logic [2:0]   req_op;
   logic [W-1:0] req_a;
   logic [W-1:0] req_b;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [W-1:0] rsp_res;
   logic         rsp_carry;
   logic         rsp_zero;
   logic         rsp_err;
   logic         busy;
   Alu4bitArgs   alu_args;
   AluCtrl       alu_ctrl;
   logic [3:0]   alu_res;
   logic         alu_carry_out;

   alu_nibble_seq #(.WIDTH(W)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_op        (req_op),
      .req_a         (req_a),
      .req_b         (req_b),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_res       (rsp_res),
      .rsp_carry     (rsp_carry),
      .rsp_zero      (rsp_zero),
      .rsp_err       (rsp_err),
      .busy          (busy),
      .alu_args      (alu_args),
      .alu_ctrl      (alu_ctrl),
      .alu_res       (alu_res),
      .alu_carry_out (alu_carry_out)
   );

   always #5 clk = ~clk;

   // behavioural alu_4bit slice
   always_comb begin
      logic [4:0] s;
      logic       cin;
      cin           = alu_ctrl.carry_disable ? 1'b0 : alu_ctrl.carry_in;
      s             = {1'b0, alu_args.d1} + {1'b0, alu_args.d2} + {4'b0, cin};
      alu_res       = '0;
      alu_carry_out = 1'b0;
      case (alu_ctrl.cmd)
         ALU_CMD_ADD: begin
            alu_res       = s[3:0];
            alu_carry_out = s[4];
         end
         ALU_CMD_XOR:   alu_res = alu_args.d1 ^ alu_args.d2;
         ALU_CMD_AND:   alu_res = alu_args.d1 & alu_args.d2;
         ALU_CMD_OR:    alu_res = alu_args.d1 | alu_args.d2;
         ALU_CMD_RSHFT: begin
            alu_res       = {alu_ctrl.carry_in, alu_args.d2[3:1]};
            alu_carry_out = alu_args.d2[0];
         end
         default: alu_res = '0;
      endcase
   end

   typedef struct {
      logic [W-1:0] res;
      logic         c;
      logic         z;
      logic         e;
      int unsigned  lat;
      int unsigned  t;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        cur;
   logic        seen;
   int unsigned cyc;
   int unsigned hs_edge;
   int unsigned acc_edge;
   int unsigned rsp_count;
   int unsigned nexp;
   int unsigned errors;
   int unsigned checks;

   logic [3:0]  tr_d2[$];
   logic        tr_cin[$];
   logic        tr_cd[$];
   logic [2:0]  tr_cmd[$];

   initial begin
      cyc       = 0;
      hs_edge   = 0;
      acc_edge  = 0;
      rsp_count = 0;
      nexp      = 0;
      errors    = 0;
      checks    = 0;
      seen      = 1'b0;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // monitor
   always @(negedge clk) begin
      if (!rst_n) begin
         seen = 1'b0;
      end else begin
         if (busy && !rsp_valid) begin
            tr_d2.push_back(alu_args.d2);
            tr_cin.push_back(alu_ctrl.carry_in);
            tr_cd.push_back(alu_ctrl.carry_disable);
            tr_cmd.push_back(alu_ctrl.cmd);
            chk("b_inv_run", 32'(alu_ctrl.b_inv), 32'd0);
         end else begin
            chk("slice_idle_zero", 32'({alu_args, alu_ctrl}), 32'd0);
         end
         if (rsp_valid) begin
            chk("req_ready_in_done", 32'(req_ready), 32'd0);
            if (!seen) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_rsp: got res 0x%0h expected no response", rsp_res);
               end else begin
                  cur = exp_q.pop_front();
                  chk("rsp_res",   32'(rsp_res),   32'(cur.res));
                  chk("rsp_carry", 32'(rsp_carry), 32'(cur.c));
                  chk("rsp_zero",  32'(rsp_zero),  32'(cur.z));
                  chk("rsp_err",   32'(rsp_err),   32'(cur.e));
                  chk("latency",   cyc + 1 - cur.t, cur.lat);
               end
               seen = 1'b1;
            end else begin
               chk("hold_res",   32'(rsp_res),   32'(cur.res));
               chk("hold_carry", 32'(rsp_carry), 32'(cur.c));
               chk("hold_zero",  32'(rsp_zero),  32'(cur.z));
               chk("hold_err",   32'(rsp_err),   32'(cur.e));
            end
            if (rsp_ready) begin
               seen    = 1'b0;
               hs_edge = cyc + 1;
               rsp_count++;
            end
         end
      end
   end

   // called at posedge+1; returns at posedge+1 after the accepting edge
   task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eres, input logic ec, input logic ez,
                       input logic ee, input int unsigned elat);
      exp_t e;
      logic ok;
      ok        = 1'b0;
      req_op    = op;
      req_a     = a;
      req_b     = b;
      req_valid = 1'b1;
      for (int i = 0; i < 60 && !ok; i++) begin
         @(negedge clk);
         if (req_ready) begin
            e.res = eres; e.c = ec; e.z = ez; e.e = ee; e.lat = elat; e.t = cyc + 1;
            exp_q.push_back(e);
            acc_edge = cyc + 1;
            nexp++;
            ok = 1'b1;
         end
      end
      if (!ok) chk("accept_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_op    = 3'd7;
      req_a     = 16'hBEEF;
      req_b     = 16'h5A5A;
   endtask

   task automatic wait_rsp(input int unsigned target);
      for (int i = 0; i < 100 && rsp_count < target; i++) begin
         @(posedge clk);
         #1;
      end
      if (rsp_count < target) chk("rsp_timeout", rsp_count, target);
   endtask

   task automatic clear_trace();
      tr_d2.delete();
      tr_cin.delete();
      tr_cd.delete();
      tr_cmd.delete();
   endtask

   task automatic run(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] eres, input logic ec, input logic ez);
      clear_trace();
      send(op, a, b, eres, ec, ez, 1'b0, 5);
      wait_rsp(nexp);
      chk("run_cycles", tr_d2.size(), 4);
   endtask

   task automatic chk_logic_trace();
      for (int i = 0; i < tr_cd.size(); i++) begin
         chk("logic_carry_disable", 32'(tr_cd[i]), 32'd1);
         chk("logic_carry_in", 32'(tr_cin[i]), 32'd0);
      end
   endtask

   task automatic chk_reset_outputs();
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_busy",      32'(busy),      32'd0);
      chk("rst_rsp_res",   32'(rsp_res),   32'd0);
      chk("rst_rsp_carry", 32'(rsp_carry), 32'd0);
      chk("rst_rsp_zero",  32'(rsp_zero),  32'd0);
      chk("rst_rsp_err",   32'(rsp_err),   32'd0);
      chk("rst_alu_args",  32'(alu_args),  32'd0);
      chk("rst_alu_ctrl",  32'(alu_ctrl),  32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_op    = 3'd0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b1;
      #3;
      chk_reset_outputs();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("req_ready_after_rst", 32'(req_ready), 32'd1);

      run(3'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1);
      run(3'd0, 16'h1234, 16'h0FCD, 16'h2201, 1'b0, 1'b0);

      run(3'd1, 16'h1234, 16'h1235, 16'hFFFF, 1'b0, 1'b0);
      run(3'd1, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b1);
      chk("sub_first_cin", 32'(tr_cin[0]), 32'd1);
      chk("sub_first_d2",  32'(tr_d2[0]),  32'hA);
      chk("sub_first_cmd", 32'(tr_cmd[0]), 32'(ALU_CMD_ADD));

      run(3'd5, 16'hDEAD, 16'h8421, 16'h4210, 1'b1, 1'b0);
      chk("rshft_d2_0", 32'(tr_d2[0]), 32'h8);
      chk("rshft_d2_1", 32'(tr_d2[1]), 32'h4);
      chk("rshft_d2_2", 32'(tr_d2[2]), 32'h2);
      chk("rshft_d2_3", 32'(tr_d2[3]), 32'h1);
      run(3'd5, 16'h0000, 16'h0010, 16'h0008, 1'b0, 1'b0);

      run(3'd2, 16'hA5A5, 16'hFFFF, 16'h5A5A, 1'b0, 1'b0);
      chk_logic_trace();
      run(3'd3, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0);
      chk_logic_trace();
      run(3'd4, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1);
      chk_logic_trace();

      // backpressure with a pending illegal request
      rsp_ready = 1'b0;
      send(3'd0, 16'h0003, 16'h0004, 16'h0007, 1'b0, 1'b0, 1'b0, 5);
      fork
         begin
            send(3'd7, 16'h1111, 16'h2222, 16'h0000, 1'b0, 1'b1, 1'b1, 1);
            chk("pending_accept_edge", acc_edge, hs_edge + 1);
         end
         begin
            for (int i = 0; i < 40 && !rsp_valid; i++) begin
               @(posedge clk);
               #1;
            end
            chk("bp_valid_seen", 32'(rsp_valid), 32'd1);
            repeat (3) @(posedge clk);
            #1;
            chk("bp_still_valid", 32'(rsp_valid), 32'd1);
            rsp_ready = 1'b1;
         end
      join
      wait_rsp(nexp);

      // asynchronous reset in the middle of RUN
      send(3'd0, 16'h1111, 16'h2222, 16'h3333, 1'b0, 1'b0, 1'b0, 5);
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("busy_before_abort", 32'(busy), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      chk_reset_outputs();
      exp_q.delete();
      nexp--;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      run(3'd0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0);

      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_nibble_seq.md
# alu_nibble_seq

Multi-cycle sequencer that runs WIDTH-bit ALU operations on the shared 4-bit ALU slice, one nibble per clock. It accepts a request over a valid/ready handshake and drives the slice's Alu4bitArgs/AluCtrl inputs nibble by nibble. It chains carry and shift bits between nibbles in internal registers and returns the assembled result, carry and zero flags over a second valid/ready handshake. It sits between the core's execute stage and a single combinational alu_4bit instance.

## Interface
- WIDTH, 16, operand/result width in bits; multiple of 4, at least 8. N = WIDTH/4 nibbles.

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept; high only in IDLE
- req_op  in  3  0 ADD, 1 SUB (a-b), 2 XOR, 3 AND, 4 OR, 5 RSHFT (logical right shift of b by 1); 6, 7 illegal
- req_a  in  WIDTH  operand a (ignored for RSHFT)
- req_b  in  WIDTH  operand b
- rsp_valid  out  1  response present, held until taken
- rsp_ready  in  1  consumer accepts response
- rsp_res  out  WIDTH  result
- rsp_carry  out  1  ADD: carry out of MSB; SUB: no-borrow (1 when a>=b unsigned); RSHFT: bit shifted out (b[0]); logic ops: 0
- rsp_zero  out  1  rsp_res == 0
- rsp_err  out  1  illegal req_op
- busy  out  1  state != IDLE
- alu_args  out  Alu4bitArgs  d1/d2 nibble to the slice
- alu_ctrl  out  AluCtrl  control to the slice; b_inv always 0
- alu_res  in  4  slice result, combinational from alu_args/alu_ctrl
- alu_carry_out  in  1  slice carry/generate out

## Operation
- FSM states IDLE, RUN, DONE.
- IDLE: req_ready=1. On req_valid: latch op, a, b (b bitwise-inverted for SUB). Clear nibble counter k and the chain bit.
  - Legal op: go to RUN.
  - Illegal op: go to DONE with rsp_res=0, rsp_carry=0, rsp_zero=1, rsp_err=1.
- RUN, one nibble per cycle, k = 0..N-1:
  - ADD/SUB/XOR/AND/OR process nibbles LSB first: nibble index k.
  - RSHFT processes MSB first: nibble index N-1-k.
  - alu_args.d1 / d2 = selected nibble of latched a / b.
  - alu_ctrl.cmd:
    - ADD for ADD/SUB, with carry_disable=0.
    - XOR/AND/OR for the matching logic op, with carry_disable=1.
    - RSHFT for RSHFT, with carry_disable=1.
  - alu_ctrl.carry_in:
    - ADD: chain register (0 at k=0).
    - SUB: chain register (1 at k=0).
    - RSHFT: chain register (0 at k=0; then bit 0 of the previous, higher b nibble).
    - Logic ops: 0.
  - Each cycle, alu_res is written into the result register at the same nibble index.
  - Chain register update: ADD/SUB load alu_carry_out; RSHFT loads b nibble bit 0.
  - At k=N-1: rsp_carry = final chain value (RSHFT: b[0]); go to DONE.
  - The counter does not wrap; it is reloaded in IDLE.
- DONE: rsp_valid=1; rsp_* outputs stable. On rsp_ready, go to IDLE. req_ready stays 0 in DONE.
- alu_args and alu_ctrl are driven to all-zero outside RUN.
- Arithmetic is modulo 2^WIDTH; there is no signed overflow flag.

## Timing
- Reset (asynchronous, immediate): state IDLE; req_ready=1 after reset deassertion; rsp_valid=0; rsp_res=0; rsp_carry=0; rsp_zero=0; rsp_err=0; busy=0; alu_args=0; alu_ctrl=0; counter and chain cleared.
- Reset mid-RUN or mid-DONE aborts the operation with no response.
- Request accepted on edge T (req_valid & req_ready).
  - Legal op: RUN during cycles T+1..T+N; rsp_valid rises after edge T+N+1, latency N+1 cycles.
  - Illegal op: rsp_valid rises after edge T+1.
- Response transferred on the first edge with rsp_valid & rsp_ready. rsp_valid drops and req_ready rises in the following cycle, so the minimum request-to-request spacing is N+2 cycles.
- req_a/req_b/req_op changes after acceptance have no effect.
- rsp_ready asserted before rsp_valid has no effect.
- alu_res is sampled at the end of the same cycle its inputs are driven; the slice is single-cycle combinational.

## Test plan
- WIDTH=16, ADD a=0xFFFF b=0x0001, rsp_ready=1 → rsp_valid exactly at T+5; res=0x0000, carry=1, zero=1, err=0. Also ADD 0x1234+0x0FCD → 0x2201, carry=0.
- SUB 0x1234-0x1235 → res=0xFFFF, carry=0, zero=0. SUB 0x0005-0x0005 → res=0x0000, carry=1, zero=1. On the first RUN cycle, check alu_ctrl.carry_in=1 and alu_args.d2=0xA (inverted 0x5).
- RSHFT b=0x8421 → res=0x4210, carry=1. RSHFT b=0x0010 → res=0x0008, carry=0. Check that nibbles are presented MSB first (d2 = 0x8, 0x4, 0x2, 0x1).
- XOR 0xA5A5^0xFFFF → 0x5A5A; AND 0xF0F0&0x3C3C → 0x3030; OR 0x0000|0x0000 → 0x0000 with zero=1. rsp_carry=0 and carry_disable=1 throughout.
- Backpressure: hold rsp_ready=0 for 3 cycles after rsp_valid. Outputs stay stable, req_ready=0, and a pending req_valid is not accepted until the cycle after the rsp handshake. Illegal op 7 → rsp at T+2 edge window with err=1, res=0.
- Reset mid-run: drop rst_n at T+2 of an ADD. All outputs go to reset values immediately without waiting for clk. After release, ADD 0x0001+0x0001 → 0x0002 with normal latency.
